matmul_job_ctrl: RTL and testbench

MATMUL_JOB_CTRL -- requirements
Module: matmul_job_ctrl

---
 rtl/matmul_job_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_matmul_job_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_job_ctrl.sv
// matmul_job_ctrl: accepts one matmul job and sequences it over an APB master.
// The job command is written to the control register. The block then waits for
// done and reads back the control register to learn the result bank (sp). It
// reads the N result elements in row-major order, then the flags word, and
// pushes every word to a valid/ready sink.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   job_valid/ready     job request handshake, job_cmd = control word to issue
//   psel..pstrb         APB master request side; prdata/pready response side
//   done                completion pulse from the datapath
//   res_*               result stream (res_flags marks the flags word, res_last the final word)
//   busy                high whenever the controller is not idle
//   err                 sticky timeout flag (only with MATMUL_CTRL_TIMEOUT_EN)
//
// Optional feature: define MATMUL_CTRL_TIMEOUT_EN to add a 16-bit WAIT_DONE
// watchdog and the err port.
module matmul_job_ctrl #(
  parameter int unsigned MAX_DIM    = 4,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [BUS_WIDTH-1:0]   job_cmd,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_WIDTH-1:0]  paddr,
  output logic [BUS_WIDTH-1:0]   pwdata,
  output logic [BUS_WIDTH/8-1:0] pstrb,
  input  logic [BUS_WIDTH-1:0]   prdata,
  input  logic                   pready,
  input  logic                   done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [BUS_WIDTH-1:0]   res_data,
  output logic                   res_flags,
  output logic                   res_last,
  output logic                   busy
`ifdef MATMUL_CTRL_TIMEOUT_EN
  ,
  output logic                   err
`endif
);

  localparam int unsigned N      = MAX_DIM * MAX_DIM;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned STRB_W = BUS_WIDTH / 8;

  typedef enum logic [3:0] {
    IDLE, WR_SET, WR_ACC, WAIT_DONE, RC_SET, RC_ACC,
    RE_SET, RE_ACC, PUSH_E, RF_SET, RF_ACC, PUSH_F
  } state_t;

  state_t               state, state_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [1:0]           sp, sp_d;
  logic [BUS_WIDTH-1:0] cmd, cmd_d;
  logic [BUS_WIDTH-1:0] data_d;

  logic                   psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_d;
  logic [BUS_WIDTH-1:0]   pwdata_d;
  logic [STRB_W-1:0]      pstrb_d;
  logic                   res_valid_d, res_flags_d, res_last_d, job_ready_d, busy_d;

`ifdef MATMUL_CTRL_TIMEOUT_EN
  logic [15:0] tcnt, tcnt_d;
  logic        err_d;
`endif

  // Next state plus next values of every registered output.
  // Outputs are decoded from the next state, so they line up with the state register.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    sp_d    = sp;
    cmd_d   = cmd;
    data_d  = res_data;
`ifdef MATMUL_CTRL_TIMEOUT_EN
    tcnt_d  = tcnt;
    err_d   = err;
`endif

    case (state)
      IDLE: begin
        if (job_valid) begin
          cmd_d   = job_cmd;
          idx_d   = '0;
          state_d = WR_SET;
        end
      end
      WR_SET: state_d = WR_ACC;
      WR_ACC: begin
        if (pready) state_d = WAIT_DONE;
`ifdef MATMUL_CTRL_TIMEOUT_EN
        tcnt_d = '0;
`endif
      end
      WAIT_DONE: begin
        if (done) begin
          state_d = RC_SET;
`ifdef MATMUL_CTRL_TIMEOUT_EN
        end else if (tcnt == 16'hFFFE) begin
          // 65535th cycle without done: give up, no results
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt + 16'd1;
`endif
        end
      end
      RC_SET: state_d = RC_ACC;
      RC_ACC: begin
        if (pready) begin
          sp_d    = prdata[3:2];
          state_d = RE_SET;
        end
      end
      RE_SET: state_d = RE_ACC;
      RE_ACC: begin
        if (pready) begin
          data_d  = prdata;
          state_d = PUSH_E;
        end
      end
      PUSH_E: begin
        if (res_ready) begin
          idx_d   = idx + IDX_W'(1);
          state_d = (idx == IDX_W'(N - 1)) ? RF_SET : RE_SET;
        end
      end
      RF_SET: state_d = RF_ACC;
      RF_ACC: begin
        if (pready) begin
          data_d  = prdata;
          state_d = PUSH_F;
        end
      end
      PUSH_F: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = 1'b0;
    paddr_d     = '0;
    pwdata_d    = '0;
    pstrb_d     = '0;
    res_valid_d = 1'b0;
    res_flags_d = 1'b0;
    res_last_d  = 1'b0;
    job_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);

    case (state_d)
      WR_SET, WR_ACC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == WR_ACC);
        pwrite_d  = 1'b1;
        pwdata_d  = cmd_d | BUS_WIDTH'(1);
        pstrb_d   = {STRB_W{1'b1}};
      end
      RC_SET, RC_ACC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == RC_ACC);
      end
      RE_SET, RE_ACC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == RE_ACC);
        // bank offset 4*sp, one 32-byte stride per element
        paddr_d   = ADDR_WIDTH'(32'd16 + (32'(sp_d) << 2) + (32'(idx_d) << 5));
      end
      RF_SET, RF_ACC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == RF_ACC);
        paddr_d   = ADDR_WIDTH'(12);
      end
      PUSH_E: res_valid_d = 1'b1;
      PUSH_F: begin
        res_valid_d = 1'b1;
        res_flags_d = 1'b1;
        res_last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      sp        <= '0;
      cmd       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= 1'b0;
      res_last  <= 1'b0;
      job_ready <= 1'b0;
      busy      <= 1'b0;
`ifdef MATMUL_CTRL_TIMEOUT_EN
      tcnt      <= '0;
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      sp        <= sp_d;
      cmd       <= cmd_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      pstrb     <= pstrb_d;
      res_valid <= res_valid_d;
      res_data  <= data_d;
      res_flags <= res_flags_d;
      res_last  <= res_last_d;
      job_ready <= job_ready_d;
      busy      <= busy_d;
`ifdef MATMUL_CTRL_TIMEOUT_EN
      tcnt      <= tcnt_d;
      err       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_matmul_job_ctrl.sv
// tb_matmul_job_ctrl: directed job sequence with randomized slave data and
// handshake timing. A job-level reference model predicts the full list of
// APB transfers and result words for each job.
module tb_matmul_job_ctrl;

  localparam int N = 16;

  logic        clk, rst;
  logic        job_valid, job_ready;
  logic [31:0] job_cmd;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, done;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_flags, res_last, busy;
`ifdef MATMUL_CTRL_TIMEOUT_EN
  logic        err;
`endif

  matmul_job_ctrl dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_cmd(job_cmd),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .done(done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_last(res_last), .busy(busy)
`ifdef MATMUL_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] seed;
  bit          q_wr[$];
  int          q_addr[$];
  logic [31:0] q_wd[$];
  logic [31:0] r_d[$];
  bit          r_f[$];
  bit          r_l[$];

  int accepts, busy_cycles, phase, wcnt, dly, prm, rrm, acc_cnt, rr_cnt;
  bit rej;

  logic        p_rst, p_psel, p_pen, p_pwrite, p_pready, p_rv, p_rr, p_rf;
  logic [15:0] p_paddr;
  logic [31:0] p_pwdata, p_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave register contents for the current job: any address maps to a seeded hash.
  function automatic logic [31:0] slave(input int a);
    return seed ^ (32'(a) * 32'h9E3779B1);
  endfunction

  task automatic drive_inputs();
    case (prm)
      0: pready = 1'b1;
      1: pready = ($urandom_range(0, 2) != 0);
      default: begin
        if (!penable) begin
          acc_cnt = 0;
          pready  = 1'b1;
        end else begin
          pready = (acc_cnt >= 3);
          acc_cnt++;
        end
      end
    endcase
    prdata = pready ? slave(int'(paddr)) : $urandom;
    case (rrm)
      0: res_ready = 1'b1;
      1: res_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (res_valid && r_d.size() == 3 && rr_cnt < 5) begin
          res_ready = 1'b0;
          rr_cnt++;
        end else res_ready = 1'b1;
      end
    endcase
    if (phase == 1) begin
      done = (wcnt == dly);
      if (done) phase = 2;
      wcnt++;
    end else begin
      done = ($urandom_range(0, 5) == 0);
    end
    job_valid = (accepts == 0) || (rej && phase == 1);
  endtask

  // One clock: log handshakes completing at this edge, then check the new outputs.
  task automatic step();
    if (psel && penable && pready) begin
      q_wr.push_back(pwrite);
      q_addr.push_back(int'(paddr));
      q_wd.push_back(pwdata);
      if (pwrite) begin
        phase = 1;
        wcnt  = 0;
      end
    end
    if (res_valid && res_ready) begin
      r_d.push_back(res_data);
      r_f.push_back(res_flags);
      r_l.push_back(res_last);
    end
    if (rej && job_valid && phase == 1) check("reject_ready", 64'(job_ready), 64'd0);
    if (job_valid && job_ready) accepts++;
    if (busy) busy_cycles++;
    p_rst = rst; p_psel = psel; p_pen = penable; p_pwrite = pwrite; p_pready = pready;
    p_paddr = paddr; p_pwdata = pwdata; p_rv = res_valid; p_rr = res_ready;
    p_rd = res_data; p_rf = res_flags;
    @(posedge clk);
    #1;
    if (!p_rst) begin
      check("invariants", 64'((!res_last || (res_valid && res_flags)) &&
                              (pwrite ? (pwdata[0] && pstrb == 4'hF) : (pwdata == 0 && pstrb == 0)) &&
                              (psel || !penable) && (job_ready == !busy) &&
                              !(res_valid && psel)), 64'd1);
      if (p_psel && (!p_pen || !p_pready)) begin
        check("apb_hold_ctl", 64'({psel, penable, pwrite}), 64'({2'b11, p_pwrite}));
        check("apb_hold_addr", 64'(paddr), 64'(p_paddr));
        check("apb_hold_wdata", 64'(pwdata), 64'(p_pwdata));
      end
      if (p_rv && !p_rr) begin
        check("res_hold_data", 64'(res_data), 64'(p_rd));
        check("res_hold_ctl", 64'({res_valid, res_flags, psel}), 64'({1'b1, p_rf, 1'b0}));
      end
    end
    drive_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({psel, penable, pwrite, res_valid, res_flags, res_last, busy, job_ready}), 64'd0);
    check({tag, "_bus"}, 64'({paddr, pstrb, pwdata, res_data}), 64'd0);
  endtask

  // mode: 0 normal, 1 reset at element 7, 2 expect timeout
  task automatic run_job(input logic [31:0] cmd, input int dly_in, input int prm_in,
                         input int rrm_in, input bit rej_in, input int mode);
    int n, sp_m, limit;
    logic [31:0] w0;
    q_wr.delete(); q_addr.delete(); q_wd.delete();
    r_d.delete(); r_f.delete(); r_l.delete();
    accepts = 0; busy_cycles = 0; phase = 0; wcnt = 0; acc_cnt = 0; rr_cnt = 0;
    dly = dly_in; prm = prm_in; rrm = rrm_in; rej = rej_in;
    w0 = slave(0);
    sp_m = int'(w0[3:2]);
    limit = (mode == 2) ? 70000 : 3000;
    job_cmd = cmd;
    job_valid = 1'b1;
    n = 0;
    while (accepts == 0 && n < 50) begin
      step();
      n++;
    end
    check("job_accepted", 64'(accepts), 64'd1);
    n = 0;
    while (!job_ready && n < limit) begin
      step();
      n++;
      if (mode == 1 && psel && !penable && !pwrite && paddr == 16'(16 + 4 * sp_m + 7 * 32)) break;
    end
    if (mode == 1) begin
      rst = 1'b1;
      step();
      check_all_zero("abort_reset");
      check("abort_apb_count", 64'(q_wr.size()), 64'd9);
      check("abort_res_count", 64'(r_d.size()), 64'd7);
      rst = 1'b0;
      step();
      check("abort_release_ready", 64'(job_ready), 64'd1);
      check("abort_no_more_res", 64'(r_d.size()), 64'd7);
      return;
    end
    check("job_returns_idle", 64'(job_ready), 64'd1);
    check("accepts_per_job", 64'(accepts), 64'd1);
    if (mode == 2) begin
`ifdef MATMUL_CTRL_TIMEOUT_EN
      check("tmo_err", 64'(err), 64'd1);
`endif
      check("tmo_apb_count", 64'(q_wr.size()), 64'd1);
      check("tmo_no_results", 64'(r_d.size()), 64'd0);
      return;
    end
    // Expected transfer list: write ctrl, read ctrl, N elements, flags.
    check("apb_count", 64'(q_wr.size()), 64'(N + 3));
    if (q_wr.size() == N + 3) begin
      for (int i = 0; i < N + 3; i++) begin
        int ea;
        bit ew;
        logic [31:0] ed;
        ew = (i == 0);
        ed = (i == 0) ? (cmd | 32'd1) : 32'd0;
        if (i < 2) ea = 0;
        else if (i < N + 2) ea = 16 + 4 * sp_m + 32 * (i - 2);
        else ea = 12;
        check($sformatf("apb_xfer%0d", i), {q_wr[i], q_addr[i][15:0], q_wd[i]}, {ew, 16'(ea), ed});
      end
    end
    check("res_count", 64'(r_d.size()), 64'(N + 1));
    if (r_d.size() == N + 1) begin
      for (int i = 0; i <= N; i++) begin
        logic [31:0] ev;
        ev = (i < N) ? slave(16 + 4 * sp_m + 32 * i) : slave(12);
        check($sformatf("res_word%0d", i), {r_f[i], r_l[i], r_d[i]}, {i == N, i == N, ev});
      end
    end
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_cmd = '0; pready = 1'b1; prdata = '0;
    done = 1'b0; res_ready = 1'b1; seed = '0;
    accepts = 1; phase = 0; prm = 0; rrm = 0; rej = 1'b0; busy_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
`ifdef MATMUL_CTRL_TIMEOUT_EN
    check("reset_err", 64'(err), 64'd0);
`endif
    rst = 1'b0;
    step();
    check("ready_after_reset", 64'({job_ready, busy}), 64'b10);

    // Basic job: cmd 0x6, bank 2, done ten cycles into WAIT_DONE.
    seed = ($urandom & 32'hFFFF_FFF3) | 32'h8;
    run_job(32'h6, 10, 0, 0, 1'b0, 0);
    if (q_wr.size() == N + 3) begin
      check("basic_wdata", 64'(q_wd[0]), 64'h7);
      check("basic_first_elem", 64'(q_addr[2]), 64'd24);
      check("basic_last_elem", 64'(q_addr[N + 1]), 64'd504);
    end

    // Minimum latency with immediate done and no stalls.
    seed = $urandom;
    run_job($urandom, 0, 0, 0, 1'b0, 0);
    check("min_latency", 64'(busy_cycles), 64'(2 + 1 + 2 + 3 * N + 3));

    seed = $urandom;
    run_job($urandom, 3, 0, 2, 1'b0, 0);   // sink stalls element 3 for 5 cycles
    seed = $urandom;
    run_job($urandom, 2, 2, 0, 1'b0, 0);   // 3 wait states on every access
    seed = $urandom;
    run_job($urandom, 8, 0, 1, 1'b1, 0);   // job_valid held during WAIT_DONE
    begin
      int nw;
      nw = 0;
      foreach (q_wr[i]) if (q_wr[i]) nw++;
      check("reject_one_write", 64'(nw), 64'd1);
    end

    for (int k = 0; k < 6; k++) begin
      seed = $urandom;
      run_job($urandom, int'($urandom_range(0, 15)), 1, 1, 1'b0, 0);
    end

    // Reset while element 7 is being read, then a clean job.
    seed = $urandom;
    run_job($urandom, 4, 1, 1, 1'b0, 1);
    seed = $urandom;
    run_job($urandom, 1, 1, 1, 1'b0, 0);

`ifdef MATMUL_CTRL_TIMEOUT_EN
    seed = $urandom;
    run_job($urandom, 32'h7FFF_FFFF, 0, 0, 1'b0, 2);
    step();
    check("tmo_err_sticky", 64'(err), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
